// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared attribute layout, slot record and front-end state types
package sprite_pkg;

    localparam int ATTR_EN        = 31;
    localparam int ATTR_HFLIP     = 30;
    localparam int ATTR_VFLIP     = 29;
    localparam int ATTR_PRI_LSB   = 27;
    localparam int ATTR_Y_LSB     = 18;
    localparam int ATTR_X_LSB     = 8;
    localparam int ATTR_FRAME_LSB = 0;

    // Slot fields are sized for the largest legal configuration and narrowed at use.
    localparam int SLOT_ROW_W = 8;
    localparam int SLOT_IDX_W = 8;

    typedef struct packed {
        logic       en;
        logic       hflip;
        logic       vflip;
        logic [1:0] pri;
        logic [8:0] y;
        logic [9:0] x;
        logic [7:0] frame;
    } attr_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            pri;
        logic                  flip;
        logic [7:0]            frame;
        logic [9:0]            col;
        logic [SLOT_ROW_W-1:0] rowoff;
        logic [SLOT_IDX_W-1:0] idx;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } fe_state_e;

endpackage

// File: rtl/sprite_prio_arbiter.sv
// rtl/sprite_prio_arbiter.sv - combinational lowest-pri / lowest-index slot select
module sprite_prio_arbiter
    import sprite_pkg::*;
#(
    parameter int MAX_SLOT = 8,
    parameter int IDXW     = 5,
    localparam int SELW    = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1
) (
    input  slot_t [MAX_SLOT-1:0] slots,
    output logic                 found,
    output logic [SELW-1:0]      sel
);

    logic [1:0]      best_pri;
    logic [IDXW-1:0] best_idx;
    logic            unused_slots;

    // Only pri/idx/valid steer the choice; the payload fields ride along.
    assign unused_slots = ^slots;

    // Linear search keeping the best (pri, idx) pair seen so far.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        best_pri = '0;
        best_idx = '0;
        for (int i = 0; i < MAX_SLOT; i++) begin
            if (slots[i].valid &&
                (!found || (slots[i].pri < best_pri) ||
                 ((slots[i].pri == best_pri) && (IDXW'(slots[i].idx) < best_idx)))) begin
                found    = 1'b1;
                sel      = SELW'(i);
                best_pri = slots[i].pri;
                best_idx = IDXW'(slots[i].idx);
            end
        end
    end

endmodule

// File: rtl/sprite_row_engine.sv
// rtl/sprite_row_engine.sv - per-scanline sprite scan and draw-request front end (option: SPRITE_VFLIP_EN)
module sprite_row_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITE = 32,
    parameter int MAX_SLOT   = 8,
    parameter int SPR_H      = 16,
    localparam int IDXW      = $clog2(NUM_SPRITE),
    localparam int ROWW      = $clog2(SPR_H)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_row,
    input  logic [9:0]      next_vcount,
    output logic [IDXW-1:0] ra,
    input  logic [31:0]     rd_data,
    output logic            draw_valid,
    input  logic            draw_ready,
    output logic [9:0]      col_base,
    output logic            flip,
    output logic [7:0]      frame_id,
    output logic [ROWW-1:0] row_off,
    output logic [IDXW-1:0] spr_idx,
    output logic            overflow,
    output logic            fe_done
);

    localparam int CNTW  = IDXW + 1;
    localparam int FILLW = $clog2(MAX_SLOT + 1);
    localparam int SELW  = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;

    fe_state_e            state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [FILLW-1:0]     fill_q, fill_d;
    slot_t [MAX_SLOT-1:0] slots_q, slots_d;
    logic [SELW-1:0]      iss_q, iss_d;
    logic                 draw_valid_q, draw_valid_d;
    logic [9:0]           col_base_q, col_base_d;
    logic                 flip_q, flip_d;
    logic [7:0]           frame_id_q, frame_id_d;
    logic [ROWW-1:0]      row_off_q, row_off_d;
    logic [IDXW-1:0]      spr_idx_q, spr_idx_d;
    logic                 overflow_q, overflow_d;
    logic                 fe_done_q, fe_done_d;

    logic                 found;
    logic [SELW-1:0]      sel;
    logic [IDXW-1:0]      eval_idx;
    logic [10:0]          v_ext, y_lo, y_hi;
    logic                 hit;
    logic [ROWW-1:0]      rowoff_raw, rowoff;
    slot_t                new_slot;

    sprite_prio_arbiter #(
        .MAX_SLOT (MAX_SLOT),
        .IDXW     (IDXW)
    ) u_arb (
        .slots (slots_q),
        .found (found),
        .sel   (sel)
    );

    // The scan counter doubles as the RAM address; it parks at NUM_SPRITE, which reads as 0.
    assign ra         = cnt_q[IDXW-1:0];
    assign draw_valid = draw_valid_q;
    assign col_base   = col_base_q;
    assign flip       = flip_q;
    assign frame_id   = frame_id_q;
    assign row_off    = row_off_q;
    assign spr_idx    = spr_idx_q;
    assign overflow   = overflow_q;
    assign fe_done    = fe_done_q;

`ifndef SPRITE_VFLIP_EN
    logic unused_vflip;
    assign unused_vflip = rd_data[ATTR_VFLIP];
`endif

    // Decode the word returned for last cycle's address; 11-bit compare keeps y+SPR_H from wrapping.
    always_comb begin
        eval_idx   = IDXW'(cnt_q - 1'b1);
        v_ext      = {1'b0, next_vcount};
        y_lo       = {2'b00, rd_data[ATTR_Y_LSB +: 9]};
        y_hi       = y_lo + 11'(SPR_H);
        hit        = rd_data[ATTR_EN] && (v_ext >= y_lo) && (v_ext < y_hi);
        rowoff_raw = next_vcount[ROWW-1:0] - rd_data[ATTR_Y_LSB +: ROWW];
`ifdef SPRITE_VFLIP_EN
        rowoff     = rd_data[ATTR_VFLIP] ? (ROWW'(SPR_H - 1) - rowoff_raw) : rowoff_raw;
`else
        rowoff     = rowoff_raw;
`endif
        new_slot.valid  = 1'b1;
        new_slot.pri    = rd_data[ATTR_PRI_LSB +: 2];
        new_slot.flip   = rd_data[ATTR_HFLIP];
        new_slot.frame  = rd_data[ATTR_FRAME_LSB +: 8];
        new_slot.col    = rd_data[ATTR_X_LSB +: 10];
        new_slot.rowoff = SLOT_ROW_W'(rowoff);
        new_slot.idx    = SLOT_IDX_W'(eval_idx);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: start_row restarts from any state; DRAIN ends once nothing is valid or in flight.
    always_comb begin
        state_d = state_q;
        if (start_row) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                SCAN:    if (cnt_q == CNTW'(NUM_SPRITE)) state_d = DRAIN;
                DRAIN:   if (!found && !draw_valid_q) state_d = IDLE;
                default: ;
            endcase
        end
    end

    // Datapath next values: slot capture in SCAN, registered request issue/retire in DRAIN.
    always_comb begin
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        slots_d      = slots_q;
        iss_d        = iss_q;
        draw_valid_d = draw_valid_q;
        col_base_d   = col_base_q;
        flip_d       = flip_q;
        frame_id_d   = frame_id_q;
        row_off_d    = row_off_q;
        spr_idx_d    = spr_idx_q;
        overflow_d   = overflow_q;
        fe_done_d    = fe_done_q;
        if (start_row) begin
            cnt_d        = '0;
            fill_d       = '0;
            slots_d      = '0;
            draw_valid_d = 1'b0;
            overflow_d   = 1'b0;
            fe_done_d    = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (cnt_q != CNTW'(NUM_SPRITE)) cnt_d = cnt_q + 1'b1;
                    if ((cnt_q != '0) && hit) begin
                        if (fill_q < FILLW'(MAX_SLOT)) begin
                            for (int i = 0; i < MAX_SLOT; i++) begin
                                if (FILLW'(i) == fill_q) slots_d[i] = new_slot;
                            end
                            fill_d = fill_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (draw_valid_q) begin
                        if (draw_ready) begin
                            draw_valid_d           = 1'b0;
                            slots_d[iss_q].valid   = 1'b0;
                        end
                    end else if (found) begin
                        draw_valid_d = 1'b1;
                        iss_d        = sel;
                        col_base_d   = slots_q[sel].col;
                        flip_d       = slots_q[sel].flip;
                        frame_id_d   = slots_q[sel].frame;
                        row_off_d    = ROWW'(slots_q[sel].rowoff);
                        spr_idx_d    = IDXW'(slots_q[sel].idx);
                    end else begin
                        fe_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            fill_q       <= '0;
            slots_q      <= '0;
            iss_q        <= '0;
            draw_valid_q <= 1'b0;
            col_base_q   <= '0;
            flip_q       <= 1'b0;
            frame_id_q   <= '0;
            row_off_q    <= '0;
            spr_idx_q    <= '0;
            overflow_q   <= 1'b0;
            fe_done_q    <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            slots_q      <= slots_d;
            iss_q        <= iss_d;
            draw_valid_q <= draw_valid_d;
            col_base_q   <= col_base_d;
            flip_q       <= flip_d;
            frame_id_q   <= frame_id_d;
            row_off_q    <= row_off_d;
            spr_idx_q    <= spr_idx_d;
            overflow_q   <= overflow_d;
            fe_done_q    <= fe_done_d;
        end
    end

endmodule

// File: tb/tb_sprite_row_engine.sv
// tb/tb_sprite_row_engine.sv - scoreboard bench for sprite_row_engine
module tb_sprite_row_engine;

    localparam int NS = 32;
    localparam int MS = 8;
    localparam int SH = 16;

    typedef struct packed {
        logic [4:0] idx;
        logic [9:0] col;
        logic       flip;
        logic [7:0] frame;
        logic [3:0] roff;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_row = 1'b0;
    logic [9:0]  next_vcount = '0;
    logic [4:0]  ra;
    logic [31:0] rd_data = '0;
    logic        draw_valid;
    logic        draw_ready = 1'b0;
    logic [9:0]  col_base;
    logic        flip;
    logic [7:0]  frame_id;
    logic [3:0]  row_off;
    logic [4:0]  spr_idx;
    logic        overflow;
    logic        fe_done;

    sprite_row_engine #(.NUM_SPRITE(NS), .MAX_SLOT(MS), .SPR_H(SH)) dut (
        .clk(clk), .reset_n(reset_n), .start_row(start_row), .next_vcount(next_vcount),
        .ra(ra), .rd_data(rd_data), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .col_base(col_base), .flip(flip), .frame_id(frame_id), .row_off(row_off),
        .spr_idx(spr_idx), .overflow(overflow), .fe_done(fe_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [NS];
    always @(posedge clk) rd_data <= mem[ra];

    int   checks = 0;
    int   failures = 0;
    req_t exp_q[$];
    int   log_idx[$];
    int   log_roff[$];
    int   nxfer = 0;
    bit   exp_ovf = 0;
    int   first_valid_k, first_done_k;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] attr(input int en, input int hf, input int vf, input int pri,
                                         input int y, input int x, input int fr);
        return {en[0], hf[0], vf[0], pri[1:0], y[8:0], x[9:0], fr[7:0]};
    endfunction

    // Reference: collect hits in index order, keep the first MS, emit by (pri, idx).
    task automatic expect_row(input int vc);
        int hits[$];
        int best;
        logic [31:0] a, b;
        req_t r;
        int y, d;
        exp_q.delete();
        exp_ovf = 0;
        for (int i = 0; i < NS; i++) begin
            a = mem[i];
            y = int'(a[26:18]);
            if (a[31] && vc >= y && vc < y + SH) hits.push_back(i);
        end
        if (hits.size() > MS) begin
            exp_ovf = 1;
            while (hits.size() > MS) void'(hits.pop_back());
        end
        while (hits.size() > 0) begin
            best = 0;
            for (int j = 1; j < hits.size(); j++) begin
                a = mem[hits[j]];
                b = mem[hits[best]];
                if (int'(a[28:27]) * NS + hits[j] < int'(b[28:27]) * NS + hits[best]) best = j;
            end
            a = mem[hits[best]];
            y = int'(a[26:18]);
            d = vc - y;
`ifdef SPRITE_VFLIP_EN
            if (a[29]) d = SH - 1 - d;
`endif
            r.idx   = 5'(hits[best]);
            r.col   = a[17:8];
            r.flip  = a[30];
            r.frame = a[7:0];
            r.roff  = 4'(d);
            exp_q.push_back(r);
            hits.delete(best);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stalled requests hold.
    req_t mon_act, mon_exp, prev_act;
    bit   prev_stall = 0;
    always @(negedge clk) begin
        mon_act = {spr_idx, col_base, flip, frame_id, row_off};
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", longint'(draw_valid), 1);
                chk("stall_data_held", longint'(mon_act), longint'(prev_act));
            end
            if (draw_valid && draw_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", longint'(mon_act), -1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("request", longint'(mon_act), longint'(mon_exp));
                end
                log_idx.push_back(int'(spr_idx));
                log_roff.push_back(int'(row_off));
                nxfer++;
            end
            prev_stall = draw_valid && !draw_ready && !start_row;
            prev_act   = mon_act;
        end
    end

    task automatic start(input int vc);
        @(posedge clk); #1;
        next_vcount = 10'(vc);
        start_row   = 1'b1;
        expect_row(vc);
        log_idx.delete();
        log_roff.delete();
        @(posedge clk); #1;
        start_row = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: first request stalled 5 cycles.
    task automatic wait_done(input int mode, input int stop_after);
        int base, stall;
        bit done;
        base = nxfer; stall = 0; done = 0;
        first_valid_k = -1; first_done_k = -1;
        for (int k = 1; k <= 600 && !done; k++) begin
            @(posedge clk); #1;
            if (draw_valid && first_valid_k < 0) first_valid_k = k;
            if (fe_done) begin first_done_k = k; done = 1; end
            if (stop_after > 0 && nxfer - base >= stop_after) done = 1;
            case (mode)
                0:       draw_ready = 1'b1;
                1:       draw_ready = 1'($urandom_range(0, 1));
                default: begin if (draw_valid) stall++; draw_ready = (stall >= 5); end
            endcase
        end
        if (!done) begin
            chk("wait_timeout", 0, 1);
        end else if (stop_after == 0) begin
            chk("queue_drained", exp_q.size(), 0);
            chk("overflow", longint'(overflow), longint'(exp_ovf));
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NS; i++) mem[i] = '0;
    endtask

    initial begin
        int vc, yv;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ra", longint'(ra), 0);
        chk("rst_draw_valid", longint'(draw_valid), 0);
        chk("rst_outputs", longint'({col_base, flip, frame_id, row_off, spr_idx}), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_fe_done", longint'(fe_done), 1);
        reset_n = 1'b1;

        // Priority ordering, row offset, latency.
        mem[4]  = attr(1, 0, 0, 2, 100, 37, 'h11);
        mem[9]  = attr(1, 1, 0, 0, 100, 200, 'h22);
        mem[20] = attr(1, 0, 0, 1, 100, 640, 'h33);
        draw_ready = 1'b1;
        start(105);
        wait_done(0, 0);
        chk("t1_first_valid_cycle", first_valid_k, NS + 2);
        chk("t1_count", log_idx.size(), 3);
        chk("t1_order0", log_idx[0], 9);
        chk("t1_order1", log_idx[1], 20);
        chk("t1_order2", log_idx[2], 4);
        chk("t1_row_off", log_roff[0], 5);

        // Overflow: ten hits, eight slots.
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = attr(1, 0, 0, 0, 300, i * 10, i);
        start(303);
        wait_done(0, 0);
        chk("t2_count", log_idx.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_idx", log_idx[i], i);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_overflow_held", longint'(overflow), 1);

        // Stalled first request.
        start(301);
        chk("t3_overflow_cleared", longint'(overflow), 0);
        wait_done(2, 0);
        chk("t3_count", log_idx.size(), 8);

        // Boundary rows near the bottom of the y range.
        clear_mem();
        mem[3] = attr(1, 0, 1, 1, 470, 100, 5);
        start(485); wait_done(0, 0);
        chk("t4_485_count", log_idx.size(), 1);
`ifdef SPRITE_VFLIP_EN
        chk("t4_485_roff", log_roff[0], 0);
`else
        chk("t4_485_roff", log_roff[0], 15);
`endif
        start(470); wait_done(0, 0);
        chk("t4_470_count", log_idx.size(), 1);
`ifdef SPRITE_VFLIP_EN
        chk("t4_470_roff", log_roff[0], 15);
`else
        chk("t4_470_roff", log_roff[0], 0);
`endif
        start(469); wait_done(0, 0);
        chk("t4_469_count", log_idx.size(), 0);
        chk("t4_empty_done_cycle", first_done_k, NS + 2);

        // Restart mid-DRAIN with requests pending.
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = attr(1, 0, 0, 0, 200, i, i);
        start(205);
        wait_done(0, 2);
        draw_ready  = 1'b0;
        start_row   = 1'b1;
        next_vcount = 10'd210;
        expect_row(210);
        log_idx.delete();
        @(posedge clk); #1;
        start_row = 1'b0;
        chk("t5_valid_dropped", longint'(draw_valid), 0);
        chk("t5_fe_done_low", longint'(fe_done), 0);
        wait_done(0, 0);
        chk("t5_rescan_count", log_idx.size(), 6);

        // Asynchronous reset mid-SCAN.
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = attr(1, 0, 0, 0, 300, i, i);
        start(305);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_scan_ra", longint'(ra), 20);
        chk("t5_scan_overflow", longint'(overflow), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_arst_ra", longint'(ra), 0);
        chk("t5_arst_overflow", longint'(overflow), 0);
        chk("t5_arst_fe_done", longint'(fe_done), 1);
        chk("t5_arst_valid", longint'(draw_valid), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Randomized rows.
        for (int r = 0; r < 20; r++) begin
            vc = int'($urandom_range(0, 479));
            for (int i = 0; i < NS; i++) begin
                yv = vc + 8 - int'($urandom_range(0, 40));
                if (yv < 0) yv = 0;
                if (yv > 511) yv = 511;
                mem[i] = attr(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), yv,
                              int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
            end
            start(vc);
            wait_done(int'($urandom_range(0, 2)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
